// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Shadow slots mirror the register usage of the instructions in EX, MEM and WB.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  uses_rs1;
      logic                  uses_rs2;
      logic                  regwrite;
      logic                  memread;
   } slot_t;

   // x0 is hardwired to zero, so a write to it never produces a value worth forwarding.
   function automatic logic slot_writes(input slot_t s, input logic [REG_ADDR_W-1:0] r);
      return s.valid && s.regwrite && (s.rd == r) && (s.rd != '0);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// ID-stage instruction fields in, pipeline sequencing and forwarding controls out.
// The master side is the datapath; the slave side is the hazard controller.
interface hazard_control_unit_if #(
   parameter int CNT_W = 32
);
   import pipe_ctrl_pkg::*;

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_regwrite;
   logic                  id_memread;
   logic                  ex_branch_taken;

   logic                  pc_write_en;
   logic                  if_id_write_en;
   logic                  flush_if_id;
   logic                  id_ex_bubble;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic                  wb_bypass_rs1;
   logic                  wb_bypass_rs2;
   logic [CNT_W-1:0]      stall_count;
   logic [CNT_W-1:0]      flush_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_regwrite, id_memread, ex_branch_taken,
      input  pc_write_en, if_id_write_en, flush_if_id, id_ex_bubble,
             fwd_a, fwd_b, wb_bypass_rs1, wb_bypass_rs2,
             stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_regwrite, id_memread, ex_branch_taken,
      output pc_write_en, if_id_write_en, flush_if_id, id_ex_bubble,
             fwd_a, fwd_b, wb_bypass_rs1, wb_bypass_rs2,
             stall_count, flush_count
   );

endinterface

// File: rtl/hazard_control_unit_fwd_select.sv
// ALU operand source select for one EX operand: the youngest in-flight writer
// of the register wins (MEM before WB), otherwise the register file value.
module fwd_select
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  uses,
   input  slot_t                 mem_slot,
   input  slot_t                 wb_slot,
   output logic [1:0]            sel
);

   // Only the destination side of the older slots matters here.
   logic unused_fields;
   assign unused_fields = ^{mem_slot.rs1, mem_slot.rs2, mem_slot.uses_rs1, mem_slot.uses_rs2,
                            mem_slot.memread, wb_slot.rs1, wb_slot.rs2, wb_slot.uses_rs1,
                            wb_slot.uses_rs2, wb_slot.memread};

   always_comb begin
      sel = FWD_REG;
      if (uses) begin
         if (slot_writes(mem_slot, rs))
            sel = FWD_MEM;
         else if (slot_writes(wb_slot, rs))
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes, EX operand
// forwarding and ID-stage WB bypass, plus saturating stall/flush counters.
module hazard_control_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   hazard_control_unit_if.slave bus
);
   import pipe_ctrl_pkg::slot_t;
   import pipe_ctrl_pkg::slot_writes;
   import pipe_ctrl_pkg::FWD_REG;

   localparam logic [REG_ADDR_W-1:0] X0 = '0;

   slot_t            slot_p0;   // EX
   slot_t            slot_p1;   // MEM
   slot_t            slot_p2;   // WB
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic       load_use;
   logic       branch_hit;
   logic       stall_act;
   logic       flush_act;
   logic       bubble;
   logic [1:0] sel_a;
   logic [1:0] sel_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      load_use   = bus.id_valid && slot_p0.valid && slot_p0.memread && (slot_p0.rd != X0) &&
                   ((bus.id_uses_rs1 && (bus.id_rs1 == slot_p0.rd)) ||
                    (bus.id_uses_rs2 && (bus.id_rs2 == slot_p0.rd)));
      branch_hit = bus.ex_branch_taken && slot_p0.valid;
      // The branch discards the ID instruction, so any stall it would cause is moot.
      flush_act  = !reset && branch_hit;
      stall_act  = !reset && load_use && !branch_hit;
      bubble     = flush_act || stall_act;
   end

   fwd_select u_fwd_a (
      .rs       (slot_p0.rs1),
      .uses     (slot_p0.valid && slot_p0.uses_rs1),
      .mem_slot (slot_p1),
      .wb_slot  (slot_p2),
      .sel      (sel_a)
   );

   fwd_select u_fwd_b (
      .rs       (slot_p0.rs2),
      .uses     (slot_p0.valid && slot_p0.uses_rs2),
      .mem_slot (slot_p1),
      .wb_slot  (slot_p2),
      .sel      (sel_b)
   );

   assign bus.pc_write_en    = !stall_act;
   assign bus.if_id_write_en = !stall_act;
   assign bus.flush_if_id    = flush_act;
   assign bus.id_ex_bubble   = bubble;
   assign bus.fwd_a          = reset ? FWD_REG : sel_a;
   assign bus.fwd_b          = reset ? FWD_REG : sel_b;
   assign bus.wb_bypass_rs1  = !reset && bus.id_valid && bus.id_uses_rs1 && slot_writes(slot_p2, bus.id_rs1);
   assign bus.wb_bypass_rs2  = !reset && bus.id_valid && bus.id_uses_rs2 && slot_writes(slot_p2, bus.id_rs2);
   assign bus.stall_count    = reset ? '0 : stall_cnt;
   assign bus.flush_count    = reset ? '0 : flush_cnt;

   // ---- ID -> EX -> MEM -> WB shadow advance ----
   always_ff @(posedge clock) begin
      if (reset) begin
         slot_p0.valid <= 1'b0;
         slot_p1.valid <= 1'b0;
         slot_p2.valid <= 1'b0;
         stall_cnt     <= '0;
         flush_cnt     <= '0;
      end else begin
         slot_p2          <= slot_p1;
         slot_p1          <= slot_p0;
         slot_p0.valid    <= bus.id_valid && !bubble;
         slot_p0.rd       <= bus.id_rd;
         slot_p0.rs1      <= bus.id_rs1;
         slot_p0.rs2      <= bus.id_rs2;
         slot_p0.uses_rs1 <= bus.id_uses_rs1;
         slot_p0.uses_rs2 <= bus.id_uses_rs2;
         slot_p0.regwrite <= bus.id_regwrite;
         slot_p0.memread  <= bus.id_memread;
         if (stall_act)
            stall_cnt <= sat_inc(stall_cnt);
         if (flush_act)
            flush_cnt <= sat_inc(flush_cnt);
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: each cycle's ID inputs are driven with the hand-derived expected
// controls pushed alongside; the negedge sampler pops and compares them.
module tb_hazard_control_unit;
   import pipe_ctrl_pkg::*;

   localparam int CNT_W = 3;
   localparam int MAXC  = (1 << CNT_W) - 1;
   localparam int IDLE  = 'b1100;   // {pc_we, ifid_we, flush, bubble}
   localparam int STALL = 'b0001;
   localparam int FLUSH = 'b1111;

   logic clock = 1'b0;
   logic reset = 1'b1;

   hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

   hazard_control_unit #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int row;
      int ctl;
      int fa;
      int fb;
      int byp;
      int sc;
      int fc;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic int sat(input int x);
      return (x > MAXC) ? MAXC : x;
   endfunction

   task automatic step(input int row, input int rst, input int v, input int rs1, input int rs2,
                       input int u1, input int u2, input int rd, input int rw, input int mr,
                       input int br, input int ctl, input int fa, input int fb, input int byp,
                       input int sc, input int fc);
      exp_t e;
      @(posedge clock);
      #1;
      reset               = (rst != 0);
      bus.id_valid        = (v != 0);
      bus.id_rs1          = REG_ADDR_W'(rs1);
      bus.id_rs2          = REG_ADDR_W'(rs2);
      bus.id_uses_rs1     = (u1 != 0);
      bus.id_uses_rs2     = (u2 != 0);
      bus.id_rd           = REG_ADDR_W'(rd);
      bus.id_regwrite     = (rw != 0);
      bus.id_memread      = (mr != 0);
      bus.ex_branch_taken = (br != 0);
      e = '{row, ctl, fa, fb, byp, sc, fc};
      sbq.push_back(e);
   endtask

   always @(negedge clock) begin
      if (sbq.size() != 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk($sformatf("r%0d ctl", e.row),
             int'({bus.pc_write_en, bus.if_id_write_en, bus.flush_if_id, bus.id_ex_bubble}), e.ctl);
         chk($sformatf("r%0d fwd_a", e.row), int'(bus.fwd_a), e.fa);
         chk($sformatf("r%0d fwd_b", e.row), int'(bus.fwd_b), e.fb);
         chk($sformatf("r%0d bypass", e.row), int'({bus.wb_bypass_rs1, bus.wb_bypass_rs2}), e.byp);
         chk($sformatf("r%0d stall_count", e.row), int'(bus.stall_count), e.sc);
         chk($sformatf("r%0d flush_count", e.row), int'(bus.flush_count), e.fc);
      end
   end

   initial begin
      bus.id_valid = 1'b0;  bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs1 = 1'b0;
      bus.id_uses_rs2 = 1'b0; bus.id_rd = '0; bus.id_regwrite = 1'b0; bus.id_memread = 1'b0;
      bus.ex_branch_taken = 1'b0;

      //    row rst v rs1 rs2 u1 u2 rd rw mr br   ctl   fa    fb    byp   sc fc
      // reset held with hazardous-looking inputs, then released idle
      step(0,  1, 1, 1, 1, 1, 1, 1, 1, 1, 1,  IDLE, 'b00, 'b00, 'b00, 0, 0);
      step(1,  1, 1, 1, 1, 1, 1, 1, 1, 1, 1,  IDLE, 'b00, 'b00, 'b00, 0, 0);
      step(2,  1, 1, 1, 1, 1, 1, 1, 1, 1, 1,  IDLE, 'b00, 'b00, 'b00, 0, 0);
      step(3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  IDLE, 'b00, 'b00, 'b00, 0, 0);
      // add x5; sub reads x5 (MEM fwd); reader of rs2=x5 (WB fwd), plus ID bypass of x5
      step(4,  0, 1, 1, 2, 1, 1, 5, 1, 0, 0,  IDLE, 'b00, 'b00, 'b00, 0, 0);
      step(5,  0, 1, 5, 6, 1, 1, 8, 1, 0, 0,  IDLE, 'b00, 'b00, 'b00, 0, 0);
      step(6,  0, 1, 0, 5, 0, 1, 9, 1, 0, 0,  IDLE, 'b10, 'b00, 'b00, 0, 0);
      step(7,  0, 1, 5, 8, 1, 1, 10, 0, 0, 0, IDLE, 'b00, 'b01, 'b10, 0, 0);
      // lw x7 then a reader of rs2=x7: one stall, then WB forward
      step(8,  0, 1, 2, 0, 1, 0, 7, 1, 1, 0,  IDLE, 'b00, 'b01, 'b00, 0, 0);
      step(9,  0, 1, 3, 7, 1, 1, 11, 1, 0, 0, STALL,'b00, 'b00, 'b00, 0, 0);
      step(10, 0, 1, 3, 7, 1, 1, 11, 1, 0, 0, IDLE, 'b00, 'b00, 'b00, 1, 0);
      step(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  IDLE, 'b00, 'b01, 'b00, 1, 0);
      // lw x0 followed by a reader of x0: no stall, no forward
      step(12, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0,  IDLE, 'b00, 'b00, 'b00, 1, 0);
      step(13, 0, 1, 0, 11, 1, 1, 12, 1, 0, 0, IDLE, 'b00, 'b00, 'b01, 1, 0);
      step(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  IDLE, 'b00, 'b00, 'b00, 1, 0);
      // branch taken with EX empty is ignored; then branch over a load-use hazard
      step(15, 0, 1, 1, 0, 1, 0, 4, 1, 1, 1,  IDLE, 'b00, 'b00, 'b00, 1, 0);
      step(16, 0, 1, 4, 12, 1, 1, 13, 1, 0, 1, FLUSH,'b00, 'b00, 'b01, 1, 0);
      step(17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  IDLE, 'b00, 'b00, 'b00, 1, 1);
      // MEM and WB both write x3: MEM wins
      step(18, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0,  IDLE, 'b00, 'b00, 'b00, 1, 1);
      step(19, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0,  IDLE, 'b00, 'b00, 'b00, 1, 1);
      step(20, 0, 1, 3, 3, 1, 1, 14, 1, 0, 0, IDLE, 'b00, 'b00, 'b00, 1, 1);
      step(21, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0,  IDLE, 'b10, 'b10, 'b10, 1, 1);
      // reset lands on a stall cycle; the cycle after is clean
      step(22, 0, 1, 0, 0, 0, 0, 6, 1, 1, 0,  IDLE, 'b01, 'b00, 'b00, 1, 1);
      step(23, 1, 1, 6, 14, 1, 1, 15, 1, 0, 0, IDLE, 'b00, 'b00, 'b00, 0, 0);
      step(24, 0, 1, 6, 14, 1, 1, 15, 1, 0, 0, IDLE, 'b00, 'b00, 'b00, 0, 0);
      step(25, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  IDLE, 'b00, 'b00, 'b00, 0, 0);
      // repeated load-use pairs drive stall_count into saturation
      for (int k = 0; k < 9; k++) begin
         step(100 + 3*k, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, IDLE, (k == 0) ? 'b00 : 'b01, 'b00, 'b00, sat(k), 0);
         step(101 + 3*k, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, STALL, 'b00, 'b00, 'b00, sat(k), 0);
         step(102 + 3*k, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, IDLE, 'b00, 'b00, 'b00, sat(k + 1), 0);
      end

      @(posedge clock);
      #1;
      chk("sb_drain", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
